// File: rtl/midi_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : midi_tx_arb_if
// Brief    : Byte-source handshake bundle between the per-input MIDI FIFOs
//            and the transmit arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface midi_tx_arb_if #(
    parameter int NCH = 4
);
    logic [8*NCH-1:0] src_data;
    logic [NCH-1:0]   src_rdy;
    logic [NCH-1:0]   src_rd;

    modport master (output src_data, output src_rdy, input src_rd);
    modport slave  (input src_data, input src_rdy, output src_rd);
endinterface
`default_nettype wire

// File: rtl/midi_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : midi_tx_arb
// Brief    : Round-robin burst-locked merge of NCH MIDI byte sources into an
//            output FIFO, drained by an 8N1 serializer onto one MIDI OUT pin.
// Revision : 1.0 - initial release
// ============================================================================
module midi_tx_arb #(
    parameter int NCH          = 4,
    parameter int DEPTH        = 16,
    parameter int BURST        = 3,
    parameter int CLKS_PER_BIT = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    midi_tx_arb_if.slave           src,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int c_ptr_w  = $clog2(NCH);
    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_baud_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_addr_w:0]   c_depth    = (c_addr_w+1)'(DEPTH);
    localparam logic [c_addr_w:0]   c_depth_m1 = (c_addr_w+1)'(DEPTH - 1);
    localparam logic [c_baud_w-1:0] c_baud_end = c_baud_w'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {ARB = 2'd0, READ = 2'd1, HOLD = 2'd2} arb_state_t;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} ser_state_t;

    arb_state_t          r_arb_state;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [c_ptr_w-1:0]  r_cur;
    logic [3:0]          r_burst_cnt;
    logic [NCH-1:0]      r_src_rd;

    ser_state_t          r_ser_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shreg;
    logic                r_tx;
    logic                r_busy;

    logic [7:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_level;

    logic                w_gnt_found;
    logic [c_ptr_w-1:0]  w_gnt_idx;
    int                  w_sum_i;
    logic [c_ptr_w-1:0]  w_cur_next;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_bit_end;
    logic [c_addr_w:0]   w_level_next;
    logic                w_ser_active_next;
    logic [7:0]          w_push_data;

    // First requesting source at or after the round-robin pointer, wrapping.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum_i     = 0;
        for (int k = 0; k < NCH; k++) begin
            w_sum_i = int'(r_rr_ptr) + k;
            if (w_sum_i >= NCH) w_sum_i = w_sum_i - NCH;
            if (!w_gnt_found && src.src_rdy[c_ptr_w'(w_sum_i)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = c_ptr_w'(w_sum_i);
            end
        end
    end

    assign w_cur_next  = (r_cur == c_ptr_w'(NCH - 1)) ? '0 : r_cur + 1'b1;
    // A READ in progress already owns one slot that has not landed yet.
    assign w_full      = (r_arb_state == READ) ? (r_level >= c_depth_m1) : (r_level >= c_depth);
    assign w_empty     = (r_level == '0);
    assign w_push      = (r_arb_state == READ);
    assign w_push_data = src.src_data[{r_cur, 3'b000} +: 8];
    assign w_bit_end   = (r_baud == c_baud_end);
    assign w_pop       = !w_empty && ((r_ser_state == IDLE) || (r_ser_state == STOP && w_bit_end));

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop)      w_level_next = r_level + 1'b1;
        else if (!w_push && w_pop) w_level_next = r_level - 1'b1;
    end

    assign w_ser_active_next = (r_ser_state == IDLE) ? w_pop
                                                     : !(r_ser_state == STOP && w_bit_end && !w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arb_state <= ARB;
            r_rr_ptr    <= '0;
            r_cur       <= '0;
            r_burst_cnt <= '0;
            r_src_rd    <= '0;
        end else begin
            r_src_rd <= '0;
            case (r_arb_state)
                ARB: begin
                    if (w_gnt_found && !w_full) begin
                        r_cur       <= w_gnt_idx;
                        r_burst_cnt <= 4'd1;
                        r_src_rd    <= NCH'(1) << w_gnt_idx;
                        r_arb_state <= READ;
                    end
                end
                READ: r_arb_state <= HOLD;
                HOLD: begin
                    if (src.src_rdy[r_cur] && (r_burst_cnt < 4'(BURST)) && !w_full) begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                        r_src_rd    <= NCH'(1) << r_cur;
                        r_arb_state <= READ;
                    end else begin
                        r_rr_ptr    <= w_cur_next;
                        r_arb_state <= ARB;
                    end
                end
                default: r_arb_state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_busy   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_next;
            r_busy  <= (w_level_next != '0) || w_ser_active_next;
        end
    end

    // tx is registered, so each state's line level is loaded on the edge entering it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ser_state <= IDLE;
            r_baud      <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_tx        <= 1'b1;
        end else begin
            case (r_ser_state)
                IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shreg     <= r_mem[r_rd_ptr];
                        r_tx        <= 1'b0;
                        r_ser_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud      <= '0;
                        r_bit_cnt   <= '0;
                        r_tx        <= r_shreg[0];
                        r_ser_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx        <= 1'b1;
                            r_ser_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shreg[r_bit_cnt + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shreg     <= r_mem[r_rd_ptr];
                            r_tx        <= 1'b0;
                            r_ser_state <= START;
                        end else begin
                            r_ser_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_ser_state <= IDLE;
            endcase
        end
    end

    assign src.src_rd = r_src_rd;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_level = r_level;
endmodule
`default_nettype wire

// File: tb/tb_midi_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_tx_arb
// Brief    : Self-checking bench: per-source byte queues, a serial-line
//            decoder and a byte-order scoreboard around midi_tx_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_tx_arb;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int BURST = 3;
    localparam int CPB   = 4;

    logic       clk;
    logic       rst_n;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;

    midi_tx_arb_if #(.NCH(NCH)) sif ();

    midi_tx_arb #(
        .NCH(NCH), .DEPTH(DEPTH), .BURST(BURST), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src(sif),
        .tx(tx), .busy(busy), .fifo_level(fifo_level)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int max_level = 0;

    logic [7:0] srcq [NCH][$];
    logic [7:0] exp_q[$];
    int         rdlog[$];
    int         starts[$];

    logic           dec_busy = 1'b0;
    int             dec_cyc  = 0;
    logic [7:0]     dec_bits = '0;
    logic [NCH-1:0] prev_rd  = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Sources present the head of their queue; consumption pops it.
    initial begin
        sif.src_rdy  = '0;
        sif.src_data = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NCH; i++) begin
                sif.src_rdy[i]         = (srcq[i].size() != 0);
                sif.src_data[8*i +: 8] = (srcq[i].size() != 0) ? srcq[i][0] : 8'h00;
            end
        end
    end

    // Consumption bookkeeping, handshake rules and serial-line decoding.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            dec_busy = 1'b0;
            exp_q.delete();
            prev_rd = '0;
        end else begin
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            total++;
            if (fifo_level > 3'(DEPTH)) begin
                bad++;
                $display("FAIL fifo_bound: level=%0d limit=%0d", fifo_level, DEPTH);
            end
            if (sif.src_rd != '0) begin
                total++;
                if ($countones(sif.src_rd) != 1 || prev_rd != '0 || fifo_level >= 3'(DEPTH)) begin
                    bad++;
                    $display("FAIL rd_pulse: src_rd=%b prev=%b level=%0d want onehot, isolated, not full",
                             sif.src_rd, prev_rd, fifo_level);
                end
                for (int i = 0; i < NCH; i++) begin
                    if (sif.src_rd[i]) begin
                        total++;
                        if (srcq[i].size() == 0) begin
                            bad++;
                            $display("FAIL rd_no_data: ch%0d read with empty source, want no read", i);
                        end else begin
                            exp_q.push_back(srcq[i].pop_front());
                            rdlog.push_back(i);
                        end
                    end
                end
            end
            prev_rd = sif.src_rd;

            if (!dec_busy) begin
                if (tx === 1'b0) begin
                    dec_busy = 1'b1;
                    dec_cyc  = 0;
                    starts.push_back(cycle);
                end
            end else begin
                dec_cyc++;
                if (dec_cyc % CPB == CPB / 2) begin
                    if (dec_cyc / CPB == 0) begin
                        total++;
                        if (tx !== 1'b0) begin
                            bad++;
                            $display("FAIL start_bit: tx=%b want 0", tx);
                        end
                    end else if (dec_cyc / CPB <= 8) begin
                        dec_bits = {tx, dec_bits[7:1]};
                    end else begin
                        total++;
                        if (tx !== 1'b1) begin
                            bad++;
                            $display("FAIL stop_bit: tx=%b want 1", tx);
                        end
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL tx_byte: got %02h want nothing", dec_bits);
                        end else begin
                            logic [7:0] e;
                            e = exp_q.pop_front();
                            if (dec_bits !== e) begin
                                bad++;
                                $display("FAIL tx_byte: got %02h want %02h", dec_bits, e);
                            end
                        end
                        dec_busy = 1'b0;
                    end
                end
            end
        end
    end

    function automatic bit sources_empty();
        for (int i = 0; i < NCH; i++) if (srcq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NCH; i++) srcq[i].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rdlog.delete();
        starts.delete();
        max_level = 0;
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy && !dec_busy && sources_empty() && sif.src_rd == '0) quiet++;
            else quiet = 0;
        end
        total++;
        if (quiet < 4) begin
            bad++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, want idle", busy, budget);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d bytes never sent, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 4;
        if (tx !== 1'b1)        begin bad++; $display("FAIL rst_tx: got %b want 1", tx); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (fifo_level !== '0)  begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        if (sif.src_rd !== '0)  begin bad++; $display("FAIL rst_rd: got %b want 0", sif.src_rd); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        frame = {1'b1, 8'h90, 1'b0};
        do_reset();
        @(posedge clk);
        srcq[0].push_back(8'h90);
        for (int c = 0; c <= 43; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++;
                if (sif.src_rd !== 4'b0001) begin bad++; $display("FAIL sb_rd: got %b want 0001", sif.src_rd); end
            end
            if (c == 2) begin
                total += 2;
                if (fifo_level !== 3'd1) begin bad++; $display("FAIL sb_level: got %0d want 1", fifo_level); end
                if (tx !== 1'b1) begin bad++; $display("FAIL sb_tx_idle: got %b want 1", tx); end
            end
            if (c >= 3 && c <= 42) begin
                total++;
                if (tx !== frame[(c-3)/CPB]) begin
                    bad++;
                    $display("FAIL sb_bit: cycle %0d got %b want %b", c, tx, frame[(c-3)/CPB]);
                end
            end
            if (c == 42) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL sb_busy_hi: got %b want 1", busy); end
            end
            if (c == 43) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL sb_busy_lo: got %b want 0", busy); end
            end
        end
        wait_idle(200);
    endtask

    task automatic test_round_robin();
        do_reset();
        @(posedge clk);
        for (int i = 0; i < NCH; i++) srcq[i].push_back(8'hA0 + 8'(i));
        wait_idle(600);
        total++;
        if (rdlog.size() != 4) begin
            bad++; $display("FAIL rr_count: got %0d reads want 4", rdlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rdlog[i] != i) begin bad++; $display("FAIL rr_order: read %0d got ch%0d want ch%0d", i, rdlog[i], i); end
            end
        end
        total++;
        if (starts.size() != 4) begin
            bad++; $display("FAIL rr_frames: got %0d want 4", starts.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (starts[i] - starts[i-1] != 10 * CPB) begin
                    bad++; $display("FAIL rr_gap: got %0d cycles want %0d", starts[i] - starts[i-1], 10 * CPB);
                end
            end
        end
    endtask

    task automatic test_burst_lock();
        int exp_log[$];
        exp_log = '{1, 1, 1, 2, 1};
        do_reset();
        @(posedge clk);
        srcq[1].push_back(8'h91); srcq[1].push_back(8'h3C);
        srcq[1].push_back(8'h64); srcq[1].push_back(8'h40);
        srcq[2].push_back(8'h92);
        wait_idle(800);
        total++;
        if (rdlog.size() != exp_log.size()) begin
            bad++; $display("FAIL burst_count: got %0d want %0d", rdlog.size(), exp_log.size());
        end else begin
            for (int i = 0; i < exp_log.size(); i++) begin
                total++;
                if (rdlog[i] != exp_log[i]) begin bad++; $display("FAIL burst_order: read %0d got ch%0d want ch%0d", i, rdlog[i], exp_log[i]); end
            end
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 8; i++) srcq[0].push_back(8'($urandom_range(0, 255)));
        wait_idle(1200);
        total += 2;
        if (rdlog.size() != 8) begin bad++; $display("FAIL full_count: got %0d want 8", rdlog.size()); end
        if (max_level != DEPTH) begin bad++; $display("FAIL full_peak: got %0d want %0d", max_level, DEPTH); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 3; i++) srcq[0].push_back(8'($urandom_range(0, 255)));
        for (int c = 0; c <= 21; c++) @(negedge clk);
        total++;
        if (fifo_level !== 3'd2) begin bad++; $display("FAIL mid_level: got %0d want 2", fifo_level); end
        #1 rst_n = 1'b0;
        #1;
        total += 4;
        if (tx !== 1'b1)       begin bad++; $display("FAIL mid_tx: got %b want 1", tx); end
        if (fifo_level !== '0) begin bad++; $display("FAIL mid_lvl0: got %0d want 0", fifo_level); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (sif.src_rd !== '0) begin bad++; $display("FAIL mid_rd: got %b want 0", sif.src_rd); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(posedge clk);
        srcq[0].push_back(8'h55);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++;
                if (sif.src_rd !== 4'b0001) begin bad++; $display("FAIL post_rd: got %b want 0001", sif.src_rd); end
            end
            if (c == 2) begin
                total++;
                if (tx !== 1'b1) begin bad++; $display("FAIL post_tx_hi: got %b want 1", tx); end
            end
            if (c == 3) begin
                total++;
                if (tx !== 1'b0) begin bad++; $display("FAIL post_tx_lo: got %b want 0", tx); end
            end
        end
        wait_idle(200);
    endtask

    task automatic test_stall_hold();
        do_reset();
        @(posedge clk);
        srcq[0].push_back(8'h11);
        srcq[3].push_back(8'h33);
        repeat (12) @(negedge clk);
        total++;
        if (rdlog.size() != 2 || rdlog[0] != 0 || rdlog[1] != 3) begin
            bad++; $display("FAIL stall_order: got %0d reads first ch%0d want ch0 then ch3",
                            rdlog.size(), (rdlog.size() != 0) ? rdlog[0] : -1);
        end
        @(posedge clk);
        srcq[0].push_back(8'h22);
        wait_idle(400);
        total++;
        if (rdlog.size() != 3 || rdlog[2] != 0) begin
            bad++; $display("FAIL stall_resume: got %0d reads want 3 ending with ch0", rdlog.size());
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            if ($urandom_range(0, 9) == 0) begin
                srcq[$urandom_range(0, NCH - 1)].push_back(8'($urandom_range(0, 255)));
                pushed++;
            end
        end
        wait_idle(8000);
        total++;
        if (rdlog.size() != pushed) begin
            bad++; $display("FAIL rand_count: got %0d reads want %0d", rdlog.size(), pushed);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_byte();
        test_round_robin();
        test_burst_lock();
        test_fifo_full();
        test_reset_mid_frame();
        test_stall_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/midi_tx_arb.md
# midi_tx_arb

Parametrised MIDI transmit block. It merges bytes from `NCH` upstream MIDI byte sources into one output FIFO through a round-robin arbiter with burst locking. An integrated 8N1 serializer drives a single MIDI output at a programmable bit rate. It sits between the router's per-input MIDI FIFOs and one physical MIDI OUT pin, and is instantiated once per output.

## Interface
Parameters:
- `NCH`, 4: number of upstream byte sources; 2..8.
- `DEPTH`, 16: output FIFO depth in bytes; a power of 2, at least 2.
- `BURST`, 3: maximum consecutive bytes taken from one source before the arbiter must re-arbitrate; 1..8.
- `CLKS_PER_BIT`, 32: clock cycles per serial bit (31250 baud × `CLKS_PER_BIT` = f_clk); at least 2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_data`  in  8*NCH  byte from source i on bits [8i+7:8i].
- `src_rdy`  in  NCH  source i has a valid byte on its slice.
- `src_rd`  out  NCH  one-cycle pulse: byte i is consumed at the end of this cycle.
- `tx`  out  1  MIDI serial output, 8N1, LSB first, idle high.
- `busy`  out  1  high while a frame is being shifted or the FIFO is non-empty.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Arbiter FSM states are ARB, READ and HOLD. Reset state is ARB, with `rr_ptr`=0, `cur`=0 and `burst_cnt`=0.
- ARB → READ when any `src_rdy` is high and the FIFO is not full.
  - The grant goes to the first set `src_rdy` at or after `rr_ptr`, wrapping modulo NCH.
  - `cur` is set to the granted index and `burst_cnt` is set to 1.
- READ lasts one cycle. `src_rd[cur]`=1 in this cycle and `src_data[cur]` is written into the FIFO at the closing edge. Next state is HOLD.
- HOLD lasts one cycle and exists so the source can update `src_rdy`/`src_data`.
  - If `src_rdy[cur]`=1, `burst_cnt`<BURST and the FIFO is not full, go to READ on `cur` and increment `burst_cnt`.
  - Otherwise set `rr_ptr`=(cur+1) mod NCH and go to ARB.
- `src_rd` is registered. At most one bit is high, and never in two consecutive cycles.
- FIFO fullness counts `fifo_level` plus any write in flight, so the FIFO never overflows. Sources simply stall.
- Serializer FSM states are IDLE, START, DATA and STOP.
  - IDLE: when the FIFO is non-empty, pop into `shreg` and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: `tx`=`shreg[bit_cnt]`, with `bit_cnt` running 0..7, each bit for CLKS_PER_BIT cycles.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - In the last cycle of STOP, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
- A FIFO push and pop in the same cycle leaves `fifo_level` unchanged and is legal when the FIFO is full or empty. When empty, the pop is not taken.
- Reset values: `tx`=1, `src_rd`=0, `busy`=0, `fifo_level`=0.
- Reset asserted mid-frame drives `tx` to 1 immediately, truncating the frame. The FIFO is emptied and both FSMs return to their reset states.

## Timing
- Latency: if `src_rdy[i]` rises in cycle 0 with the FIFO empty and the serializer idle:
  - `src_rd[i]`=1 in cycle 1;
  - `fifo_level`=1 in cycle 2;
  - the pop happens at the end of cycle 2;
  - `tx` falls at the start of cycle 3.
- Frame length is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
- Arbiter throughput is at most 1 byte per 2 cycles.
- `busy` is registered and falls in the first IDLE cycle with the FIFO empty.

## Test plan
- **Single byte:** with CLKS_PER_BIT=4, present 0x90 on ch0 once.
  - `src_rd`=0001 in cycle 1 and `tx` falls in cycle 3.
  - The `tx` bit sequence, each bit 4 cycles, is 0,0,0,0,0,1,0,0,1,1.
  - `busy` falls after 40 `tx` cycles.
- **Round-robin:** BURST=1, all four sources hold `src_rdy`=1 with bytes 0xA0+i.
  - `src_rd` order is ch0,1,2,3,0,1.
  - `tx` emits A0,A1,A2,A3 back-to-back with no gap.
- **Burst lock:** BURST=3, ch1 offers 0x91,0x3C,0x64 while ch2 offers 0x92 continuously.
  - Three ch1 reads occur in consecutive READ states, then ch2.
  - With BURST=1 the sources alternate 1,2,1,2.
- **FIFO full:** DEPTH=4, CLKS_PER_BIT=8, ch0 always ready.
  - `src_rd` stops with `fifo_level`=4 and no overflow.
  - Reads resume exactly one per pop, and all bytes come out of `tx` in order.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 with 2 bytes queued.
  - `tx`=1, `fifo_level`=0, `busy`=0 and `src_rd`=0 immediately.
  - After release, a new byte transmits cleanly with the cycle-3 latency.
- **Stall during HOLD:** ch0 drops `src_rdy` during HOLD after 1 byte while ch3 is ready.
  - The next grant is ch3 with `rr_ptr`=1.
  - ch0 is not read again until it reasserts `src_rdy`.
